// File: rtl/tmr_scrub_controller_if.sv
// Bus between a triplicated datapath supervisor and its environment:
// replica samples and scrub acknowledge in, voted result and health status out.
interface tmr_scrub_controller_if #(
    parameter int unsigned W     = 2,
    parameter int unsigned CNT_W = 8
);
    logic             in_valid;
    logic [W-1:0]     rep0;
    logic [W-1:0]     rep1;
    logic [W-1:0]     rep2;
    logic             scrub_ack;
    logic             voted_valid;
    logic [W-1:0]     voted;
    logic [2:0]       mismatch;
    logic             uncorrectable;
    logic             scrub_req;
    logic [1:0]       scrub_sel;
    logic [2:0]       replica_failed;
    logic             degraded;
    logic [CNT_W-1:0] err_cnt0;
    logic [CNT_W-1:0] err_cnt1;
    logic [CNT_W-1:0] err_cnt2;

    // Environment side: drives replica samples and scrub acknowledge.
    modport master (
        output in_valid, rep0, rep1, rep2, scrub_ack,
        input  voted_valid, voted, mismatch, uncorrectable, scrub_req, scrub_sel,
               replica_failed, degraded, err_cnt0, err_cnt1, err_cnt2
    );

    // Controller side.
    modport slave (
        input  in_valid, rep0, rep1, rep2, scrub_ack,
        output voted_valid, voted, mismatch, uncorrectable, scrub_req, scrub_sel,
               replica_failed, degraded, err_cnt0, err_cnt1, err_cnt2
    );
endinterface

// File: rtl/tmr_scrub_controller.sv
// tmr_scrub_controller: registered voting over three replica outputs,
// per-replica error/streak tracking, one-at-a-time scrub sequencing and
// retirement of replicas that exhaust their scrub budget.
module tmr_scrub_controller #(
    parameter int unsigned W         = 2,
    parameter int unsigned THRESH    = 4,
    parameter int unsigned HOLDOFF   = 8,
    parameter int unsigned MAX_SCRUB = 3,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    tmr_scrub_controller_if.slave bus
);
    localparam int unsigned STK_W = $clog2(THRESH + 1);
    localparam int unsigned SCR_W = $clog2(MAX_SCRUB + 1);
    localparam int unsigned HLD_W = $clog2(HOLDOFF + 1);

    typedef enum logic [1:0] {MONITOR, SCRUB_REQ, HOLD} state_t;

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic             req_q, req_d;
    logic [HLD_W-1:0] hold_q, hold_d;
    logic [2:0]       failed_q, failed_d;
    logic             vvalid_q;
    logic [W-1:0]     voted_q, voted_d;
    logic [2:0]       mism_q, mism_d;
    logic             unc_q, unc_d;
    logic [STK_W-1:0] streak_q [3];
    logic [STK_W-1:0] streak_d [3];
    logic [SCR_W-1:0] scrubs_q [3];
    logic [SCR_W-1:0] scrubs_d [3];
    logic [CNT_W-1:0] err_q [3];
    logic [CNT_W-1:0] err_d [3];

    logic [W-1:0]     rep [3];
    logic [2:0]       ign;
    logic [1:0]       n_ign;
    logic [W-1:0]     vote;
    logic             vote_unc;
    logic             found;
    logic [1:0]       pick;

    // Vote over replicas that are neither retired nor in post-scrub holdoff.
    always_comb begin
        rep[0] = bus.rep0;
        rep[1] = bus.rep1;
        rep[2] = bus.rep2;
        for (int unsigned i = 0; i < 3; i++) begin
            ign[i] = failed_q[i] | ((state_q == HOLD) && (sel_q == 2'(i)));
        end
        n_ign    = 2'(ign[0]) + 2'(ign[1]) + 2'(ign[2]);
        vote     = (rep[0] & rep[1]) | (rep[1] & rep[2]) | (rep[0] & rep[2]);
        vote_unc = (rep[0] != rep[1]) && (rep[1] != rep[2]) && (rep[0] != rep[2]);
        if (n_ign == 2'd1) begin
            if (ign[0]) begin
                vote     = rep[1];
                vote_unc = (rep[1] != rep[2]);
            end else if (ign[1]) begin
                vote     = rep[0];
                vote_unc = (rep[0] != rep[2]);
            end else begin
                vote     = rep[0];
                vote_unc = (rep[0] != rep[1]);
            end
        end else if (n_ign >= 2'd2) begin
            vote_unc = 1'b1;
            if (!ign[0]) begin
                vote = rep[0];
            end else if (!ign[1]) begin
                vote = rep[1];
            end else if (!ign[2]) begin
                vote = rep[2];
            end else begin
                vote = rep[0];
            end
        end
    end

    // Next-state: sample bookkeeping first, then FSM actions override streaks.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        req_d    = req_q;
        hold_d   = hold_q;
        failed_d = failed_q;
        voted_d  = voted_q;
        mism_d   = mism_q;
        unc_d    = unc_q;
        found    = 1'b0;
        pick     = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            streak_d[i] = streak_q[i];
            scrubs_d[i] = scrubs_q[i];
            err_d[i]    = err_q[i];
        end

        if (bus.in_valid) begin
            voted_d = vote;
            unc_d   = vote_unc;
            for (int unsigned i = 0; i < 3; i++) begin
                mism_d[i] = 1'b0;
                if (!ign[i]) begin
                    if (rep[i] != vote) begin
                        mism_d[i] = 1'b1;
                        if (err_q[i] != '1) begin
                            err_d[i] = err_q[i] + 1'b1;
                        end
                        if (streak_q[i] != STK_W'(THRESH)) begin
                            streak_d[i] = streak_q[i] + 1'b1;
                        end
                    end else begin
                        streak_d[i] = '0;
                    end
                end
            end
        end

        for (int unsigned i = 0; i < 3; i++) begin
            if (!found && !failed_q[i] && (streak_q[i] == STK_W'(THRESH))) begin
                found = 1'b1;
                pick  = 2'(i);
            end
        end

        case (state_q)
            MONITOR: begin
                if (found) begin
                    for (int unsigned i = 0; i < 3; i++) begin
                        if (pick == 2'(i)) begin
                            if (scrubs_q[i] == SCR_W'(MAX_SCRUB)) begin
                                failed_d[i] = 1'b1;
                                streak_d[i] = '0;
                            end else begin
                                sel_d   = pick;
                                req_d   = 1'b1;
                                state_d = SCRUB_REQ;
                            end
                        end
                    end
                end
            end
            SCRUB_REQ: begin
                if (bus.scrub_ack) begin
                    req_d   = 1'b0;
                    hold_d  = HLD_W'(HOLDOFF);
                    state_d = HOLD;
                    for (int unsigned i = 0; i < 3; i++) begin
                        if (sel_q == 2'(i)) begin
                            scrubs_d[i] = scrubs_q[i] + 1'b1;
                            streak_d[i] = '0;
                        end
                    end
                end
            end
            HOLD: begin
                if (hold_q == HLD_W'(1)) begin
                    hold_d  = '0;
                    state_d = MONITOR;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: begin
                state_d = MONITOR;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MONITOR;
            sel_q    <= '0;
            req_q    <= 1'b0;
            hold_q   <= '0;
            failed_q <= '0;
            vvalid_q <= 1'b0;
            voted_q  <= '0;
            mism_q   <= '0;
            unc_q    <= 1'b0;
            for (int unsigned i = 0; i < 3; i++) begin
                streak_q[i] <= '0;
                scrubs_q[i] <= '0;
                err_q[i]    <= '0;
            end
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            req_q    <= req_d;
            hold_q   <= hold_d;
            failed_q <= failed_d;
            vvalid_q <= bus.in_valid;
            voted_q  <= voted_d;
            mism_q   <= mism_d;
            unc_q    <= unc_d;
            for (int unsigned i = 0; i < 3; i++) begin
                streak_q[i] <= streak_d[i];
                scrubs_q[i] <= scrubs_d[i];
                err_q[i]    <= err_d[i];
            end
        end
    end

    assign bus.voted_valid    = vvalid_q;
    assign bus.voted          = voted_q;
    assign bus.mismatch       = mism_q;
    assign bus.uncorrectable  = unc_q;
    assign bus.scrub_req      = req_q;
    assign bus.scrub_sel      = sel_q;
    assign bus.replica_failed = failed_q;
    assign bus.degraded       = (failed_q[0] & failed_q[1]) | (failed_q[1] & failed_q[2]) |
                                (failed_q[0] & failed_q[2]);
    assign bus.err_cnt0       = err_q[0];
    assign bus.err_cnt1       = err_q[1];
    assign bus.err_cnt2       = err_q[2];
endmodule
